// File: rtl/tug_rope_core_pkg.sv
// rtl/tug_rope_core_pkg.sv - shared state encoding, rope constants and score helper
package tug_rope_core_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_WIN_L = 2'd1,
        ST_WIN_R = 2'd2
    } state_t;

    localparam logic [2:0] POS_CENTER    = 3'd3;
    localparam logic [2:0] POS_MAX       = 3'd6;
    localparam logic [6:0] WIN_L_PATTERN = 7'b1110000;
    localparam logic [6:0] WIN_R_PATTERN = 7'b0000111;

    function automatic logic [6:0] pos_to_score(input logic [2:0] pos);
        return 7'b0000001 << pos;
    endfunction

endpackage

// File: rtl/tug_rope_core_if.sv
// rtl/tug_rope_core_if.sv - game inputs and score/tally outputs of the rope engine
interface tug_rope_core_if #(
    parameter int TALLY_W = 4
);
    logic               slowen;
    logic               pb_left;
    logic               pb_right;
    logic [6:0]         score;
    logic               wingame;
    logic [TALLY_W-1:0] wins_left;
    logic [TALLY_W-1:0] wins_right;

    modport master (
        output slowen, pb_left, pb_right,
        input  score, wingame, wins_left, wins_right
    );

    modport slave (
        input  slowen, pb_left, pb_right,
        output score, wingame, wins_left, wins_right
    );
endinterface

// File: rtl/tug_rope_core_btn_press_detect.sv
// rtl/tug_rope_core_btn_press_detect.sv - button synchronizer, debouncer and press pulse
module btn_press_detect #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             level_prev_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // cnt_q counts consecutive synchronized samples that disagree with the accepted level
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= btn_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
        end
    end

    assign press_o = level_q & ~level_prev_q;

endmodule

// File: rtl/tug_rope_core.sv
// rtl/tug_rope_core.sv - tug-of-war rope position, win detection, win hold and tallies
module tug_rope_core
    import tug_rope_core_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int HOLD_TICKS = 13,
    parameter int TALLY_W    = 4
) (
    input  logic            clk,
    input  logic            rst,
    tug_rope_core_if.slave  bus
);
    localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

    state_t             state_q, state_d;
    logic [2:0]         pos_q, pos_d;
    logic [6:0]         score_q, score_d;
    logic               wingame_q, wingame_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [TALLY_W-1:0] wins_l_q, wins_l_d;
    logic [TALLY_W-1:0] wins_r_q, wins_r_d;
    logic               press_l, press_r;

    btn_press_detect #(.DEB_CYCLES(DEB_CYCLES)) u_left (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.pb_left),
        .press_o (press_l)
    );

    btn_press_detect #(.DEB_CYCLES(DEB_CYCLES)) u_right (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.pb_right),
        .press_o (press_r)
    );

    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        score_d   = score_q;
        wingame_d = wingame_q;
        hold_d    = hold_q;
        wins_l_d  = wins_l_q;
        wins_r_d  = wins_r_q;
        unique case (state_q)
            ST_PLAY: begin
                if (press_l && !press_r) begin
                    if (pos_q == POS_MAX - 3'd1) begin
                        state_d   = ST_WIN_L;
                        pos_d     = POS_MAX;
                        score_d   = WIN_L_PATTERN;
                        wingame_d = 1'b1;
                        hold_d    = '0;
                        if (wins_l_q != '1) wins_l_d = wins_l_q + 1'b1;
                    end else if (pos_q < POS_MAX) begin
                        pos_d   = pos_q + 3'd1;
                        score_d = pos_to_score(pos_q + 3'd1);
                    end
                end else if (press_r && !press_l) begin
                    if (pos_q == 3'd1) begin
                        state_d   = ST_WIN_R;
                        pos_d     = 3'd0;
                        score_d   = WIN_R_PATTERN;
                        wingame_d = 1'b1;
                        hold_d    = '0;
                        if (wins_r_q != '1) wins_r_d = wins_r_q + 1'b1;
                    end else if (pos_q != 3'd0) begin
                        pos_d   = pos_q - 3'd1;
                        score_d = pos_to_score(pos_q - 3'd1);
                    end
                end
            end
            ST_WIN_L, ST_WIN_R: begin
                // Presses are ignored here, so one landing on the recentre cycle is dropped too
                if (bus.slowen) begin
                    wingame_d = 1'b0;
                    if (hold_q == HOLD_W'(HOLD_TICKS - 1)) begin
                        state_d = ST_PLAY;
                        pos_d   = POS_CENTER;
                        score_d = pos_to_score(POS_CENTER);
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_PLAY;
                pos_d   = POS_CENTER;
                score_d = pos_to_score(POS_CENTER);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_PLAY;
            pos_q     <= POS_CENTER;
            score_q   <= 7'b0001000;
            wingame_q <= 1'b0;
            hold_q    <= '0;
            wins_l_q  <= '0;
            wins_r_q  <= '0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            score_q   <= score_d;
            wingame_q <= wingame_d;
            hold_q    <= hold_d;
            wins_l_q  <= wins_l_d;
            wins_r_q  <= wins_r_d;
        end
    end

    assign bus.score      = score_q;
    assign bus.wingame    = wingame_q;
    assign bus.wins_left  = wins_l_q;
    assign bus.wins_right = wins_r_q;

endmodule

// File: tb/tb_tug_rope_core.sv
// tb/tb_tug_rope_core.sv - table-driven and sequence checks with a score-change scoreboard
module tb_tug_rope_core;

    localparam logic [6:0] CENTER = 7'b0001000;
    localparam logic [6:0] WIN_R  = 7'b0000111;

    logic clk = 1'b0;
    logic rst = 1'b0;

    tug_rope_core_if #(.TALLY_W(4)) bus ();

    tug_rope_core #(
        .DEB_CYCLES (4),
        .HOLD_TICKS (13),
        .TALLY_W    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       l;
        logic       r;
        int         hold;
        int         n_slow;
        logic [6:0] exp_score;
        logic       exp_wg;
        logic [3:0] exp_wl;
        logic [3:0] exp_wr;
    } vec_t;

    vec_t       vecs [8];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] sb_q [$];
    logic [6:0] model_score = CENTER;
    logic [6:0] last_score;
    logic       mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_score(input logic [6:0] s);
        if (s != model_score) begin
            sb_q.push_back(s);
            model_score = s;
        end
    endtask

    task automatic push_btn(input logic l, input logic r, input int hold);
        @(negedge clk);
        bus.pb_left  = l;
        bus.pb_right = r;
        repeat (hold) @(negedge clk);
        bus.pb_left  = 1'b0;
        bus.pb_right = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic slow_pulse();
        @(negedge clk);
        bus.slowen = 1'b1;
        @(negedge clk);
        bus.slowen = 1'b0;
    endtask

    task automatic right_press(input logic [6:0] exp);
        expect_score(exp);
        push_btn(1'b0, 1'b1, 10);
    endtask

    // Score-change monitor: every change must match the next expected value in order
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && bus.score !== last_score) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_change", 32'(bus.score), 32'(last_score));
                end else begin
                    check("sb_score", 32'(bus.score), 32'(sb_q.pop_front()));
                end
                last_score = bus.score;
            end
        end
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 10,  0, 7'b0010000, 1'b0, 4'd1 - 4'd1, 4'd0};
        vecs[1] = '{1'b1, 1'b0, 10,  0, 7'b0100000, 1'b0, 4'd0, 4'd0};
        vecs[2] = '{1'b1, 1'b0, 10,  0, 7'b1110000, 1'b1, 4'd1, 4'd0};
        vecs[3] = '{1'b0, 1'b0,  0, 13, CENTER,     1'b0, 4'd1, 4'd0};
        vecs[4] = '{1'b1, 1'b1, 10,  0, CENTER,     1'b0, 4'd1, 4'd0};
        vecs[5] = '{1'b0, 1'b1, 50,  0, 7'b0000100, 1'b0, 4'd1, 4'd0};
        vecs[6] = '{1'b0, 1'b1,  3,  0, 7'b0000100, 1'b0, 4'd1, 4'd0};
        vecs[7] = '{1'b1, 1'b0, 10,  0, CENTER,     1'b0, 4'd1, 4'd0};

        bus.slowen   = 1'b0;
        bus.pb_left  = 1'b0;
        bus.pb_right = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_score",   32'(bus.score),      32'(CENTER));
        check("reset_wingame", 32'(bus.wingame),    32'd0);
        check("reset_wl",      32'(bus.wins_left),  32'd0);
        check("reset_wr",      32'(bus.wins_right), 32'd0);
        rst = 1'b1;
        last_score = bus.score;
        mon_en = 1'b1;

        for (int i = 0; i < 8; i++) begin
            expect_score(vecs[i].exp_score);
            push_btn(vecs[i].l, vecs[i].r, vecs[i].hold);
            for (int k = 0; k < vecs[i].n_slow; k++) slow_pulse();
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_score", i),   32'(bus.score),      32'(vecs[i].exp_score));
            check($sformatf("vec%0d_wingame", i), 32'(bus.wingame),    32'(vecs[i].exp_wg));
            check($sformatf("vec%0d_wl", i),      32'(bus.wins_left),  32'(vecs[i].exp_wl));
            check($sformatf("vec%0d_wr", i),      32'(bus.wins_right), 32'(vecs[i].exp_wr));
        end

        // Right win, then the 13-tick hold with wingame and ignored-press checks
        right_press(7'b0000100);
        right_press(7'b0000010);
        right_press(WIN_R);
        check("rwin_score",   32'(bus.score),      32'(WIN_R));
        check("rwin_wingame", 32'(bus.wingame),    32'd1);
        check("rwin_wr",      32'(bus.wins_right), 32'd1);
        @(negedge clk);
        bus.slowen = 1'b1;
        #1;
        check("wg_in_first_slow", 32'(bus.wingame), 32'd1);
        @(negedge clk);
        bus.slowen = 1'b0;
        #1;
        check("wg_after_first_slow", 32'(bus.wingame), 32'd0);
        push_btn(1'b1, 1'b0, 10);
        check("win_press_ignored", 32'(bus.score), 32'(WIN_R));
        for (int k = 0; k < 11; k++) slow_pulse();
        repeat (2) @(negedge clk);
        check("hold_12_score", 32'(bus.score), 32'(WIN_R));
        expect_score(CENTER);
        slow_pulse();
        repeat (2) @(negedge clk);
        check("hold_13_score",   32'(bus.score),   32'(CENTER));
        check("hold_13_wingame", 32'(bus.wingame), 32'd0);

        // Four more right wins; the last one is left in WIN_R for the reset check
        for (int rnd = 2; rnd <= 5; rnd++) begin
            right_press(7'b0000100);
            right_press(7'b0000010);
            right_press(WIN_R);
            check($sformatf("round%0d_wr", rnd), 32'(bus.wins_right), 32'(rnd));
            if (rnd < 5) begin
                for (int k = 0; k < 12; k++) slow_pulse();
                expect_score(CENTER);
                slow_pulse();
                repeat (2) @(negedge clk);
            end
        end

        expect_score(CENTER);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_win_score",   32'(bus.score),      32'(CENTER));
        check("rst_mid_win_wingame", 32'(bus.wingame),    32'd0);
        check("rst_mid_win_wr",      32'(bus.wins_right), 32'd0);
        check("rst_mid_win_wl",      32'(bus.wins_left),  32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tug_rope_core.md
Name: tug_rope_core

Overview:
- Upstream game engine for the victory cheer stage.
- Turns two player push-buttons into the rope position and shows it as a 7-LED one-hot pattern on `score`.
- Detects a win, presents the win pattern on `score` and raises `wingame` so the cheer stage restarts its animation.
- Holds the win for a fixed number of slow ticks, then recentres the rope for the next round. Keeps per-player win tallies.

Parameters:
- DEB_CYCLES, 4: consecutive clk samples a synchronized button must be stable before its level is accepted.
- HOLD_TICKS, 13: slowen pulses spent in WIN before auto-recentre. Matches the 13-step cheer sequence.
- TALLY_W, 4: width of each win tally.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- slowen  in  1  one-clk-wide tick, synchronous to clk; also clocks the downstream cheer stage
- pb_left  in  1  left player button, raw, asynchronous
- pb_right  in  1  right player button, raw, asynchronous
- score  out  7  rope LED pattern; bit 0 is the right end
- wingame  out  1  win flag to the cheer stage
- wins_left  out  TALLY_W  left player win tally
- wins_right  out  TALLY_W  right player win tally

Behaviour:
- Reset (rst low, asynchronous): state=PLAY, pos=3, score=7'b0001000, wingame=0, tallies=0, hold counter=0, synchronizers and debouncers cleared.
- Button path:
  - 2-flop synchronizer, then debounce: the accepted level changes only after DEB_CYCLES equal samples.
  - A press is the rising edge of the accepted level: a 1-clk pulse.
  - Holding a button produces exactly one press.
- pos is a 3-bit index 0..6. In PLAY, score = 1 << pos. Registered: score updates the clk after the press pulse.
- PLAY transitions:
  - Left press only: pos+1. Right press only: pos-1.
  - Both presses in the same clk: no move (tie).
  - Left press at pos==5 moves to 6 and enters WIN_L. Right press at pos==1 moves to 0 and enters WIN_R.
  - pos never leaves 0..6. No wrap-around.
- Entering WIN_L:
  - score=7'b1110000.
  - wins_left increments, saturating at all-ones.
  - wingame=1, hold counter=0.
- Entering WIN_R:
  - score=7'b0000111.
  - wins_right increments, saturating.
  - wingame=1, hold counter=0.
- wingame timing:
  - Stays 1 from the win cycle through the clk cycle containing the first slowen pulse after the win.
  - Clears on the following clk.
  - Guarantees wingame is high at one slowen rising edge, which restarts the cheer counter.
- WIN_L / WIN_R:
  - Button presses are ignored; debouncers keep running.
  - Each slowen pulse increments the hold counter.
  - When the counter reaches HOLD_TICKS: go to PLAY, pos=3, score=7'b0001000.
- Simultaneous events:
  - A win and a slowen pulse in the same clk: that slowen does not count toward the hold and does not clear wingame.
  - A press pulse in the clk where WIN returns to PLAY is dropped.
- Reset mid-WIN: everything returns to reset values, including tallies.
- Invariant: score is always one-hot in PLAY and one of the two win patterns in WIN. Bits 2:0 are all set only in WIN_R.

Decomposition:
- Shared package holds:
  - state encoding: PLAY, WIN_L, WIN_R
  - POS_CENTER=3, POS_MAX=6
  - WIN_L_PATTERN=7'b1110000, WIN_R_PATTERN=7'b0000111
- One sub-module, `btn_press_detect`: synchronizer, debounce counter and rising-edge pulse. Instantiated twice.

Test Plan:
- Reset then 3 clean left presses -> score 0010000, 0100000, then 1110000 with wingame=1; wins_left=1.
- From centre, left and right pressed in the same clk -> score stays 0001000, no tally change.
- Right button held high for 50 clk -> exactly one move, score 0000100.
- Right win followed by 13 slowen pulses -> wingame clears after the first slowen; score stays 0000111 until the 13th pulse, then 0001000; presses during WIN cause no change.
- Button glitch shorter than DEB_CYCLES (3 clk high) -> no move.
- rst pulled low mid-WIN_R with wins_right=5 -> score=0001000, wingame=0, wins_right=0 immediately, without waiting for a clk edge.
